irq_ctrl: RTL and testbench
===========================

Name: irq_ctrl

Overview:
- Interrupt controller directly upstream of mips_top; produces the core's 4-bit INT input.
- Captures rising edges on raw interrupt sources into sticky pending bits.
- Applies a software mask and selects one pending source by fixed priority.
- Drives a one-hot request to the core and holds it until the core acknowledges; then clears the served bit and returns to idle.

Parameters:
- N_IRQ, 4: number of sources; fixed at 4 for the current core, ID width 2.
- MASK_RST, 4'hF: mask register value after reset (all enabled).
- HOLDOFF, 1: idle cycles forced after an ack before the next request may assert (range 0..7).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- irq_in  in  4  raw interrupt sources, may be single-cycle pulses
- mask_we  in  1  mask write strobe
- mask_wd  in  4  new mask value (1 = enabled)
- int_ack  in  1  core acknowledge of the current request
- int_out  out  4  one-hot request to core INT[3:0], zero when idle
- int_req  out  1  OR of int_out
- int_id  out  2  index of the source being served
- pending  out  4  sticky pending register (unmasked view)
- mask  out  4  current mask register

Behaviour:
- Reset: the reset is synchronous and active-high; on rst=1 at a clk edge, all of the following load.
  - int_out=0, int_req=0, int_id=0, pending=0, mask=MASK_RST.
  - Edge-history register=0, FSM=IDLE, holdoff counter=0.
  - A reset asserted mid-REQ drops int_req in the same edge; no ack is required.
- Edge detect: irq_prev <= irq_src each cycle. rise = irq_src & ~irq_prev. pending <= (pending & ~clr) | rise.
- Set/clear collision: if a rise and a clear hit the same bit in the same cycle, set wins and the bit stays pending.
- Mask:
  - mask_we loads mask_wd next cycle.
  - Masking never clears pending; a masked pending bit is held and served once unmasked.
- Eligible vector: eligible = pending & mask. Priority is fixed, with the lowest index highest (bit0 > bit1 > bit2 > bit3).
- FSM states: IDLE, REQ, HOLD.
- IDLE:
  - If eligible != 0, latch int_id = highest-priority eligible index.
  - int_out <= one-hot(id), int_req <= 1, go to REQ.
  - Otherwise stay.
- REQ:
  - int_out and int_id are frozen; they do not change if a higher-priority source arrives or if the mask changes (no preemption).
  - On int_ack=1: clear pending[int_id], int_out <= 0, int_req <= 0.
  - Then go to HOLD if HOLDOFF>0, else IDLE.
  - If the served bit is masked while in REQ, the request stays until ack.
- HOLD: count HOLDOFF cycles, then go to IDLE.
- int_ack in IDLE or HOLD: ignored.
- Latency: rise sampled at edge N, so pending is set after edge N; int_req is high after edge N+1 (2 cycles from the source edge). With the sync feature enabled, add 2.
- Level held high: produces only one pending set per rising edge; the source must deassert and reassert to re-request.

Optional Feature:
- IRQ_SYNC_EN defined:
  - irq_in passes through a 2-flop synchronizer (reset to 0) before edge detect.
  - Request latency becomes 4 cycles.
- Undefined: irq_src = irq_in directly, for synchronous on-chip sources; latency is 2 cycles.

Test Plan:
- Reset then idle 10 cycles -> int_out=0, int_req=0, pending=0, mask=4'hF throughout.
- Single 1-cycle pulse irq_in=4'b0100 (no sync) -> int_req=1, int_out=4'b0100, int_id=2 exactly 2 cycles later. Ack held 1 cycle -> pending=0 and int_out=0 next cycle.
- Simultaneous pulse irq_in=4'b1111 with HOLDOFF=1 -> served in order id 0,1,2,3. Each request follows its ack after 1 HOLD cycle and 1 IDLE cycle, and the final pending=0.
- Mask write 4'b1110, then pulse irq_in=4'b0001 -> pending=4'b0001 and no request. Mask write 4'hF -> request id 0 issued 1 cycle after the mask update.
- During REQ for id 3, pulse irq_in=4'b0001 -> int_out stays 4'b1000 until ack; id 0 is requested next. Pulse bit 3 in the same cycle as its ack -> pending[3] remains 1.
- Assert rst while int_req=1 -> next cycle int_req=0, pending=0, mask=4'hF. An int_ack after reset has no effect.

Source files
------------

// File: rtl/irq_ctrl.sv
// irq_ctrl: edge-capturing, maskable, fixed-priority interrupt
// controller that drives the core's one-hot INT[3:0] until acked.
// Optional: define IRQ_SYNC_EN to add a 2-flop input synchronizer.
module irq_ctrl #(
    parameter int         N_IRQ    = 4,
    parameter logic [3:0] MASK_RST = 4'hF,
    parameter int         HOLDOFF  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IRQ-1:0] irq_in,
    input  logic             mask_we,
    input  logic [N_IRQ-1:0] mask_wd,
    input  logic             int_ack,
    output logic [N_IRQ-1:0] int_out,
    output logic             int_req,
    output logic [1:0]       int_id,
    output logic [N_IRQ-1:0] pending,
    output logic [N_IRQ-1:0] mask
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        HOLD
    } state_t;

    state_t           state;
    logic [2:0]       hold_cnt;
    logic [N_IRQ-1:0] irq_src;
    logic [N_IRQ-1:0] irq_prev;
    logic [N_IRQ-1:0] rise;
    logic [N_IRQ-1:0] clr;
    logic [N_IRQ-1:0] eligible;
    logic [1:0]       sel_id;

`ifdef IRQ_SYNC_EN
    logic [N_IRQ-1:0] sync_q1;
    logic [N_IRQ-1:0] sync_q2;

    // Two-stage synchronizer for sources from other clock domains
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= irq_in;
            sync_q2 <= sync_q1;
        end
    end

    assign irq_src = sync_q2;
`else
    assign irq_src = irq_in;
`endif

    assign rise     = irq_src & ~irq_prev;
    assign eligible = pending & mask;

    // Served bit is cleared only when the core acks in REQ
    always_comb begin
        clr = '0;
        if (state == REQ && int_ack) begin
            clr[int_id] = 1'b1;
        end
    end

    // Fixed priority: lowest index wins, so scan high to low
    always_comb begin
        sel_id = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                sel_id = i[1:0];
            end
        end
    end

    // Edge history, sticky pending (set beats clear) and mask register
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_prev <= '0;
            pending  <= '0;
            mask     <= MASK_RST;
        end else begin
            irq_prev <= irq_src;
            pending  <= (pending & ~clr) | rise;
            if (mask_we) begin
                mask <= mask_wd;
            end
        end
    end

    // Request FSM: issue, hold until ack, then optional holdoff gap
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            hold_cnt <= '0;
            int_out  <= '0;
            int_req  <= 1'b0;
            int_id   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (|eligible) begin
                        int_id          <= sel_id;
                        int_out         <= '0;
                        int_out[sel_id] <= 1'b1;
                        int_req         <= 1'b1;
                        state           <= REQ;
                    end
                end
                REQ: begin
                    if (int_ack) begin
                        int_out <= '0;
                        int_req <= 1'b0;
                        if (HOLDOFF > 0) begin
                            hold_cnt <= 3'(HOLDOFF - 1);
                            state    <= HOLD;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                HOLD: begin
                    if (hold_cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        hold_cnt <= hold_cnt - 3'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: scenario tasks with a queue of expected interrupt
// ids, pushed at stimulus time and popped when a request appears.
module tb_irq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] irq_in;
    logic       mask_we;
    logic [3:0] mask_wd;
    logic       int_ack;
    logic [3:0] int_out;
    logic       int_req;
    logic [1:0] int_id;
    logic [3:0] pending;
    logic [3:0] mask;

    int checks   = 0;
    int failures = 0;

    logic [1:0] exp_q[$];

    irq_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .irq_in  (irq_in),
        .mask_we (mask_we),
        .mask_wd (mask_wd),
        .int_ack (int_ack),
        .int_out (int_out),
        .int_req (int_req),
        .int_id  (int_id),
        .pending (pending),
        .mask    (mask)
    );

    always #5 clk = ~clk;

    // advance one clock; inputs change and outputs are sampled 1ns after
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // wait (bounded) for a request, then check it against the queue head
    task automatic serve_next(input string name);
        logic [1:0] eid;
        logic [3:0] eoh;
        int n;
        n = 0;
        while (!int_req && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (!int_req) begin
            failures++;
            $display("FAIL %s_timeout int_req=%0b required 1", name, int_req);
        end
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL %s_queue_empty got id=%0d required none", name, int_id);
        end else begin
            eid = exp_q.pop_front();
            eoh = 4'b0001 << eid;
            if (int_id !== eid || int_out !== eoh) begin
                failures++;
                $display("FAIL %s_id got id=%0d out=%b required id=%0d out=%b",
                         name, int_id, int_out, eid, eoh);
            end
        end
    endtask

    task automatic ack_and_settle();
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        logic bad;
        rst = 1'b1;
        irq_in = '0;
        mask_we = 1'b0;
        mask_wd = '0;
        int_ack = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (int_out !== 4'h0 || int_req !== 1'b0 || pending !== 4'h0 || mask !== 4'hF)
                bad = 1'b1;
            tick();
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL reset_idle out=%b req=%b pend=%b mask=%b required 0000 0 0000 1111",
                     int_out, int_req, pending, mask);
        end
    endtask

    task automatic test_single();
        irq_in = 4'b0100;
        exp_q.push_back(2'd2);
        tick();
        irq_in = '0;
        checks++;
        if (int_req !== 1'b0 || pending !== 4'b0100) begin
            failures++;
            $display("FAIL single_lat1 req=%b pend=%b required 0 0100", int_req, pending);
        end
        tick();
        checks++;
        if (int_req !== 1'b1) begin
            failures++;
            $display("FAIL single_lat2 req=%b required 1", int_req);
        end
        serve_next("single");
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        checks++;
        if (pending !== 4'h0 || int_out !== 4'h0 || int_req !== 1'b0) begin
            failures++;
            $display("FAIL single_ack pend=%b out=%b req=%b required 0000 0000 0",
                     pending, int_out, int_req);
        end
        tick();
        tick();
    endtask

    task automatic test_back_to_back();
        irq_in = 4'b1111;
        for (int k = 0; k < 4; k++) exp_q.push_back(2'(k));
        tick();
        irq_in = '0;
        tick();
        for (int k = 0; k < 4; k++) begin
            serve_next("b2b");
            int_ack = 1'b1;
            tick();
            int_ack = 1'b0;
            checks++;
            if (int_req !== 1'b0) begin
                failures++;
                $display("FAIL b2b_hold k=%0d req=%b required 0", k, int_req);
            end
            tick();
            checks++;
            if (int_req !== 1'b0) begin
                failures++;
                $display("FAIL b2b_idle k=%0d req=%b required 0", k, int_req);
            end
            tick();
            checks++;
            if (int_req !== (k < 3)) begin
                failures++;
                $display("FAIL b2b_next k=%0d req=%b required %0b", k, int_req, k < 3);
            end
        end
        checks++;
        if (pending !== 4'h0) begin
            failures++;
            $display("FAIL b2b_pend pend=%b required 0000", pending);
        end
    endtask

    task automatic test_mask();
        logic bad;
        mask_we = 1'b1;
        mask_wd = 4'b1110;
        tick();
        mask_we = 1'b0;
        checks++;
        if (mask !== 4'b1110) begin
            failures++;
            $display("FAIL mask_wr mask=%b required 1110", mask);
        end
        irq_in = 4'b0001;
        tick();
        irq_in = '0;
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (int_req !== 1'b0 || pending !== 4'b0001) bad = 1'b1;
            tick();
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL mask_hold req=%b pend=%b required 0 0001", int_req, pending);
        end
        mask_we = 1'b1;
        mask_wd = 4'hF;
        exp_q.push_back(2'd0);
        tick();
        mask_we = 1'b0;
        checks++;
        if (mask !== 4'hF || int_req !== 1'b0) begin
            failures++;
            $display("FAIL mask_restore mask=%b req=%b required 1111 0", mask, int_req);
        end
        tick();
        checks++;
        if (int_req !== 1'b1) begin
            failures++;
            $display("FAIL mask_unmask_lat req=%b required 1", int_req);
        end
        serve_next("mask");
        ack_and_settle();
    endtask

    task automatic test_no_preempt();
        irq_in = 4'b1000;
        exp_q.push_back(2'd3);
        tick();
        irq_in = '0;
        tick();
        serve_next("npre3");
        irq_in = 4'b0001;
        exp_q.push_back(2'd0);
        tick();
        irq_in = '0;
        mask_we = 1'b1;
        mask_wd = 4'b0111;
        tick();
        mask_we = 1'b0;
        tick();
        checks++;
        if (int_out !== 4'b1000 || int_id !== 2'd3 || pending !== 4'b1001) begin
            failures++;
            $display("FAIL npre_frozen out=%b id=%0d pend=%b required 1000 3 1001",
                     int_out, int_id, pending);
        end
        mask_we = 1'b1;
        mask_wd = 4'hF;
        tick();
        mask_we = 1'b0;
        int_ack = 1'b1;
        irq_in = 4'b1000;
        exp_q.push_back(2'd3);
        tick();
        int_ack = 1'b0;
        irq_in = '0;
        checks++;
        if (pending !== 4'b1001 || int_out !== 4'h0) begin
            failures++;
            $display("FAIL npre_collide pend=%b out=%b required 1001 0000", pending, int_out);
        end
        serve_next("npre0");
        ack_and_settle();
        serve_next("npre3b");
        ack_and_settle();
    endtask

    task automatic test_reset_mid();
        irq_in = 4'b0010;
        exp_q.push_back(2'd1);
        tick();
        irq_in = 4'b0100;
        tick();
        irq_in = '0;
        mask_we = 1'b1;
        mask_wd = 4'b0011;
        tick();
        mask_we = 1'b0;
        serve_next("rstmid");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (int_req !== 1'b0 || int_out !== 4'h0 || pending !== 4'h0 || mask !== 4'hF) begin
            failures++;
            $display("FAIL rstmid_state req=%b out=%b pend=%b mask=%b required 0 0000 0000 1111",
                     int_req, int_out, pending, mask);
        end
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        tick();
        checks++;
        if (int_req !== 1'b0 || pending !== 4'h0) begin
            failures++;
            $display("FAIL rstmid_ack req=%b pend=%b required 0 0000", int_req, pending);
        end
        irq_in = 4'b0001;
        exp_q.push_back(2'd0);
        tick();
        irq_in = '0;
        tick();
        serve_next("rstmid_after");
        ack_and_settle();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_mask();
        test_no_preempt();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL queue_drain left=%0d required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
